// File: rtl/etc_vehicle_tracker_if.sv
// Lane-side signal bundle for the multi-vehicle ETC tracker: loop sensors,
// tag-reader pulse and override in; measurement, event pulses and barrier out.
interface etc_vehicle_tracker_if #(
    parameter int WIDTH_MS = 9,
    parameter int DEPTH    = 4
);
    localparam int OW = $clog2(DEPTH + 1);

    logic                sensor1;
    logic                sensor2;
    logic                sensor3;
    logic                valid_Epass;
    logic                enable;
    logic [WIDTH_MS-1:0] transit_ms;
    logic                overspeed;
    logic                done;
    logic                violation;
    logic                err;
    logic [OW-1:0]       occupancy;
    logic                barrier;

    // Lane equipment / bench side.
    modport master (
        output sensor1, sensor2, sensor3, valid_Epass, enable,
        input  transit_ms, overspeed, done, violation, err, occupancy, barrier
    );

    // Tracker side.
    modport slave (
        input  sensor1, sensor2, sensor3, valid_Epass, enable,
        output transit_ms, overspeed, done, violation, err, occupancy, barrier
    );
endinterface

// File: rtl/etc_vehicle_tracker.sv
// Tracks up to DEPTH vehicles from the entry loop to the barrier loop, times the
// sensor1->sensor2 transit in ms, and drives the barrier from the head record.
module etc_vehicle_tracker #(
    parameter int DEPTH    = 4,
    parameter int WIDTH_MS = 9,
    parameter int SYS_FREQ = 50000000,
    parameter int MIN_MS   = 36
) (
    input  logic                  clk,
    input  logic                  reset_n,
    etc_vehicle_tracker_if.slave  lane
);
    localparam int TICKS = SYS_FREQ / 1000;
    localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int IW    = $clog2(DEPTH);
    localparam int OW    = $clog2(DEPTH + 1);

    // Circular slot index for any non-negative offset sum.
    function automatic logic [IW-1:0] idx(input logic [31:0] a);
        return IW'(a % 32'(DEPTH));
    endfunction

    // Synchroniser + edge-detect pipelines: [1] is the synced level, [2] its previous value.
    logic [2:0]          r_s1_pipe;
    logic [2:0]          r_s2_pipe;
    logic [2:0]          r_s3_pipe;
    logic [1:0]          r_ep_pipe;

    logic [PW-1:0]       r_presc;
    logic [WIDTH_MS-1:0] r_ms_now;

    logic [WIDTH_MS-1:0] r_ts   [DEPTH];
    logic                r_paid [DEPTH];
    logic [IW-1:0]       r_rd;
    logic [OW-1:0]       r_occ;
    // Records between rd and mid, i.e. already past sensor2 (mid - rd).
    logic [OW-1:0]       r_npast;

    logic [WIDTH_MS-1:0] r_transit;
    logic                r_over;
    logic                r_done;
    logic                r_viol;
    logic                r_err;
    logic                r_hold;

    logic                w_e1;
    logic                w_e2;
    logic                w_e3;
    logic                w_ep;
    logic                w_s3_sync;
    logic [IW-1:0]       w_wr;
    logic [IW-1:0]       w_wr_m1;
    logic [IW-1:0]       w_mid;
    logic                w_e2_ok;
    logic                w_e2_err;
    logic [OW-1:0]       w_past_a;
    logic                w_pop;
    logic                w_e3_err;
    logic [OW-1:0]       w_occ_pop;
    logic                w_push;
    logic                w_e1_err;
    logic [OW-1:0]       w_occ_next;
    logic                w_ep_ok;
    logic [OW-1:0]       w_npast_next;
    logic [WIDTH_MS-1:0] w_transit;
    logic                w_over;
    logic                w_hold_next;

    assign w_e1      = r_s1_pipe[1] & ~r_s1_pipe[2];
    assign w_e2      = r_s2_pipe[1] & ~r_s2_pipe[2];
    assign w_e3      = r_s3_pipe[1] & ~r_s3_pipe[2];
    assign w_s3_sync = r_s3_pipe[1];
    assign w_ep      = r_ep_pipe[1];

    assign w_wr    = idx(32'(r_rd) + 32'(r_occ));
    assign w_wr_m1 = idx(32'(r_rd) + 32'(r_occ) + 32'(DEPTH) - 32'd1);
    assign w_mid   = idx(32'(r_rd) + 32'(r_npast));

    // sensor2 sees the pre-pop queue, so a head record can pass sensor2 and
    // sensor3 in the same cycle; the pop then uses the advanced mid.
    assign w_e2_ok   = w_e2 && (r_npast != r_occ);
    assign w_e2_err  = w_e2 && (r_npast == r_occ);
    assign w_past_a  = r_npast + OW'(w_e2_ok);

    assign w_pop     = w_e3 && (r_occ != '0);
    assign w_e3_err  = w_e3 && ((r_occ == '0) || (w_past_a == '0));
    assign w_occ_pop = r_occ - OW'(w_pop);

    assign w_push     = w_e1 && (w_occ_pop != OW'(DEPTH));
    assign w_e1_err   = w_e1 && !w_push;
    assign w_occ_next = w_occ_pop + OW'(w_push);
    assign w_ep_ok    = w_ep && (w_occ_next != '0);

    always_comb begin
        w_npast_next = w_past_a;
        if (w_pop) begin
            w_npast_next = (w_past_a == '0) ? '0 : (w_past_a - OW'(1));
        end
    end

    assign w_transit = r_ms_now - r_ts[w_mid];
    assign w_over    = (32'(w_transit) < 32'(MIN_MS));

    assign w_hold_next = ((r_occ != '0) && (r_npast != '0) && r_paid[r_rd])
                       || (r_hold && w_s3_sync);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_pipe <= '0;
            r_s2_pipe <= '0;
            r_s3_pipe <= '0;
            r_ep_pipe <= '0;
            r_presc   <= '0;
            r_ms_now  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ts[i]   <= '0;
                r_paid[i] <= 1'b0;
            end
            r_rd      <= '0;
            r_occ     <= '0;
            r_npast   <= '0;
            r_transit <= '0;
            r_over    <= 1'b0;
            r_done    <= 1'b0;
            r_viol    <= 1'b0;
            r_err     <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_s1_pipe <= {r_s1_pipe[1:0], lane.sensor1};
            r_s2_pipe <= {r_s2_pipe[1:0], lane.sensor2};
            r_s3_pipe <= {r_s3_pipe[1:0], lane.sensor3};
            r_ep_pipe <= {r_ep_pipe[0], lane.valid_Epass};

            if (r_presc == PW'(TICKS - 1)) begin
                r_presc  <= '0;
                r_ms_now <= r_ms_now + WIDTH_MS'(1);
            end else begin
                r_presc  <= r_presc + PW'(1);
            end

            // A paid pulse arriving with its own vehicle marks the fresh record directly.
            if (w_push) begin
                r_ts[w_wr]   <= r_ms_now;
                r_paid[w_wr] <= w_ep_ok;
            end else if (w_ep_ok) begin
                r_paid[w_wr_m1] <= 1'b1;
            end

            if (w_pop) begin
                r_rd <= idx(32'(r_rd) + 32'd1);
            end
            r_occ   <= w_occ_next;
            r_npast <= w_npast_next;

            if (w_e2_ok) begin
                r_transit <= w_transit;
                r_over    <= w_over;
            end
            r_done <= w_e2_ok;
            r_viol <= w_pop && !r_paid[r_rd];
            r_err  <= w_e1_err || w_e2_err || w_e3_err;
            r_hold <= w_hold_next;
        end
    end

    assign lane.transit_ms = r_transit;
    assign lane.overspeed  = r_over;
    assign lane.done       = r_done;
    assign lane.violation  = r_viol;
    assign lane.err        = r_err;
    assign lane.occupancy  = r_occ;
    assign lane.barrier    = lane.enable | r_hold;

endmodule

// File: tb/tb_etc_vehicle_tracker.sv
// Directed bench for etc_vehicle_tracker at 4 clk/ms, DEPTH=2, MIN_MS=10.
module tb_etc_vehicle_tracker;
    localparam int DEPTH    = 2;
    localparam int WIDTH_MS = 9;
    localparam int SYS_FREQ = 4000;
    localparam int MIN_MS   = 10;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    etc_vehicle_tracker_if #(.WIDTH_MS(WIDTH_MS), .DEPTH(DEPTH)) lane_if ();

    etc_vehicle_tracker #(
        .DEPTH(DEPTH), .WIDTH_MS(WIDTH_MS), .SYS_FREQ(SYS_FREQ), .MIN_MS(MIN_MS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .lane    (lane_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input logic [31:0] obs,
                             input int lo, input int hi);
        n_cmp++;
        assert ((obs >= 32'(lo)) && (obs <= 32'(hi))) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        lane_if.sensor1     = 1'b0;
        lane_if.sensor2     = 1'b0;
        lane_if.sensor3     = 1'b0;
        lane_if.valid_Epass = 1'b0;
        lane_if.enable      = 1'b0;

        // Reset state
        do_reset();
        tick(2);
        chk("rst_transit", 32'(lane_if.transit_ms), 0);
        chk("rst_overspeed", 32'(lane_if.overspeed), 0);
        chk("rst_done", 32'(lane_if.done), 0);
        chk("rst_violation", 32'(lane_if.violation), 0);
        chk("rst_err", 32'(lane_if.err), 0);
        chk("rst_occupancy", 32'(lane_if.occupancy), 0);
        chk("rst_barrier", 32'(lane_if.barrier), 0);

        // Paid vehicle: Epass two cycles after sensor1, sensor2 80 clk later
        lane_if.sensor1 = 1'b1;
        tick(2);
        lane_if.valid_Epass = 1'b1;
        tick(1);
        lane_if.valid_Epass = 1'b0;
        chk("paid_occ_push", 32'(lane_if.occupancy), 1);
        lane_if.sensor1 = 1'b0;
        tick(77);
        chk("paid_barrier_before_s2", 32'(lane_if.barrier), 0);
        lane_if.sensor2 = 1'b1;
        tick(3);
        chk("paid_done", 32'(lane_if.done), 1);
        chk_range("paid_transit", 32'(lane_if.transit_ms), 19, 21);
        chk("paid_overspeed", 32'(lane_if.overspeed), 0);
        tick(1);
        chk("paid_done_one_cycle", 32'(lane_if.done), 0);
        chk("paid_barrier_open", 32'(lane_if.barrier), 1);
        lane_if.sensor2 = 1'b0;
        tick(10);
        lane_if.sensor3 = 1'b1;
        tick(3);
        chk("paid_occ_pop", 32'(lane_if.occupancy), 0);
        chk("paid_no_violation", 32'(lane_if.violation), 0);
        chk("paid_barrier_at_s3", 32'(lane_if.barrier), 1);
        tick(5);
        chk("paid_barrier_held", 32'(lane_if.barrier), 1);
        lane_if.sensor3 = 1'b0;
        tick(3);
        chk("paid_barrier_closed", 32'(lane_if.barrier), 0);

        // Unpaid vehicle
        do_reset();
        lane_if.sensor1 = 1'b1;
        tick(3);
        chk("unpaid_occ_push", 32'(lane_if.occupancy), 1);
        lane_if.sensor1 = 1'b0;
        tick(77);
        lane_if.sensor2 = 1'b1;
        tick(3);
        chk("unpaid_done", 32'(lane_if.done), 1);
        chk_range("unpaid_transit", 32'(lane_if.transit_ms), 19, 21);
        tick(1);
        chk("unpaid_barrier_closed", 32'(lane_if.barrier), 0);
        lane_if.sensor2 = 1'b0;
        tick(5);
        lane_if.sensor3 = 1'b1;
        tick(3);
        chk("unpaid_violation", 32'(lane_if.violation), 1);
        chk("unpaid_occ_pop", 32'(lane_if.occupancy), 0);
        chk("unpaid_no_err", 32'(lane_if.err), 0);
        tick(1);
        chk("unpaid_violation_one_cycle", 32'(lane_if.violation), 0);
        lane_if.sensor3 = 1'b0;

        // Overspeed across the 511->0 wrap: entry near ms 508, sensor2 16 clk later
        do_reset();
        tick(2032);
        lane_if.sensor1 = 1'b1;
        tick(3);
        lane_if.sensor1 = 1'b0;
        tick(13);
        lane_if.sensor2 = 1'b1;
        tick(3);
        chk("wrap_done", 32'(lane_if.done), 1);
        chk("wrap_transit", 32'(lane_if.transit_ms), 4);
        chk("wrap_overspeed", 32'(lane_if.overspeed), 1);
        lane_if.sensor2 = 1'b0;

        // Full queue: third entry dropped, sensor2 reports the first vehicle
        do_reset();
        lane_if.sensor1 = 1'b1;
        tick(3);
        chk("full_occ1", 32'(lane_if.occupancy), 1);
        chk("full_err1", 32'(lane_if.err), 0);
        lane_if.sensor1 = 1'b0;
        tick(3);
        lane_if.sensor1 = 1'b1;
        tick(3);
        chk("full_occ2", 32'(lane_if.occupancy), 2);
        chk("full_err2", 32'(lane_if.err), 0);
        lane_if.sensor1 = 1'b0;
        tick(3);
        lane_if.sensor1 = 1'b1;
        tick(3);
        chk("full_err3", 32'(lane_if.err), 1);
        chk("full_occ_stays", 32'(lane_if.occupancy), 2);
        lane_if.sensor1 = 1'b0;
        tick(3);
        lane_if.sensor2 = 1'b1;
        tick(3);
        chk("full_done", 32'(lane_if.done), 1);
        chk_range("full_transit_first", 32'(lane_if.transit_ms), 4, 5);
        chk("full_overspeed", 32'(lane_if.overspeed), 1);
        chk("full_s2_no_err", 32'(lane_if.err), 0);
        lane_if.sensor2 = 1'b0;

        // Override: barrier follows enable combinationally; tracking continues
        do_reset();
        tick(1);
        chk("ovr_barrier_off", 32'(lane_if.barrier), 0);
        lane_if.enable = 1'b1;
        #1;
        chk("ovr_barrier_on", 32'(lane_if.barrier), 1);
        lane_if.sensor1 = 1'b1;
        tick(3);
        chk("ovr_occ", 32'(lane_if.occupancy), 1);
        lane_if.sensor1 = 1'b0;
        tick(37);
        lane_if.sensor2 = 1'b1;
        tick(3);
        chk("ovr_done", 32'(lane_if.done), 1);
        chk("ovr_transit_boundary", 32'(lane_if.transit_ms), 10);
        chk("ovr_overspeed_boundary", 32'(lane_if.overspeed), 0);
        lane_if.sensor2 = 1'b0;
        lane_if.enable  = 1'b0;
        #1;
        chk("ovr_barrier_release", 32'(lane_if.barrier), 0);

        // Reset mid-operation with one record outstanding
        tick(2);
        chk("midrst_occ_before", 32'(lane_if.occupancy), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_transit", 32'(lane_if.transit_ms), 0);
        chk("midrst_overspeed", 32'(lane_if.overspeed), 0);
        chk("midrst_occ", 32'(lane_if.occupancy), 0);
        chk("midrst_barrier", 32'(lane_if.barrier), 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        lane_if.sensor3 = 1'b1;
        tick(3);
        chk("midrst_s3_err", 32'(lane_if.err), 1);
        chk("midrst_s3_violation", 32'(lane_if.violation), 0);
        chk("midrst_s3_occ", 32'(lane_if.occupancy), 0);
        tick(1);
        chk("midrst_err_one_cycle", 32'(lane_if.err), 0);
        lane_if.sensor3 = 1'b0;
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/etc_vehicle_tracker.md
# etc_vehicle_tracker

Multi-vehicle successor to the single-vehicle non-stop ETC lane controller. It tracks up to DEPTH vehicles between the entry sensor (sensor1) and the barrier sensor (sensor3) in an in-order record queue. For each vehicle it measures transit time from sensor1 to sensor2 in milliseconds and flags overspeed. It drives the barrier from the E-pass status of the vehicle at the head of the queue and reports unpaid exits as violations.

## Interface
- DEPTH, 4: maximum vehicles tracked at once (≥2).
- WIDTH_MS, 9: width of the ms timestamp counter and of transit_ms.
- SYS_FREQ, 50000000: clock frequency in Hz. TICKS_PER_MS = SYS_FREQ/1000, which must be ≥1.
- MIN_MS, 36: a transit shorter than this many ms is overspeed.
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- sensor1  in  1  entry loop, asynchronous level, high while a vehicle is present.
- sensor2  in  1  speed loop, asynchronous level.
- sensor3  in  1  barrier loop, asynchronous level.
- valid_Epass  in  1  clk-synchronous one-cycle pulse from the tag reader; means the newest vehicle has paid.
- enable  in  1  maintenance override; forces the barrier open.
- transit_ms  out  WIDTH_MS  last measured transit time; holds its value between measurements.
- overspeed  out  1  (transit_ms < MIN_MS) for the last measurement; holds.
- done  out  1  one-cycle pulse when transit_ms/overspeed update.
- violation  out  1  one-cycle pulse when an unpaid vehicle reaches sensor3.
- err  out  1  one-cycle pulse on a protocol anomaly (see Operation).
- occupancy  out  $clog2(DEPTH+1)  number of records in the queue.
- barrier  out  1  1 = open.

## Operation
- Each sensor passes through a 2-flop synchroniser and then a rising-edge detector (e1, e2, e3).
- valid_Epass passes through a 2-flop delay so it aligns with e1 for a raw event presented in the same cycle.
- Prescaler counts 0..TICKS_PER_MS-1. ms_now (WIDTH_MS bits) increments when the prescaler wraps and wraps modulo 2^WIDTH_MS.
- Record = {ts[WIDTH_MS], paid}. The queue is circular with three pointers: wr (next free slot), mid (oldest record not yet past sensor2), rd (head).
- Ordering invariant: rd ≤ mid ≤ wr, taken in queue order.
- Events are processed in this order in the same cycle: e3 pop, then e1 push, then Epass, then e2. e2 acts on the pre-pop state, so a record can pass sensor2 and sensor3 in the same cycle.
- e1: if occupancy = DEPTH, the vehicle is dropped and err pulses. Otherwise a record {ms_now, 0} is written at wr and wr advances.
- Epass (delayed): if occupancy > 0 after the push, set paid on record wr-1. Otherwise ignore it (no err).
- e2: if mid = wr, err pulses. Otherwise:
  - transit_ms ← (ms_now − ts[mid]) mod 2^WIDTH_MS;
  - overspeed ← (transit < MIN_MS);
  - done pulses;
  - mid advances.
- e3 with occupancy 0: err pulses and nothing else happens.
- e3 with a head record present:
  - the record is popped (rd advances);
  - if mid = rd before the pop, mid advances with rd, no transit is reported, and err pulses;
  - if the head is unpaid, violation pulses.
- hold register, next value = (head exists ∧ head past sensor2 ∧ head.paid) ∨ (hold ∧ sensor3_sync). The barrier therefore stays open until the paid vehicle clears sensor3.
- barrier = enable ∨ hold. This is combinational in enable. Tracking continues normally while enable = 1.

## Timing
- Reset values: transit_ms = 0, overspeed = 0, done = 0, violation = 0, err = 0, occupancy = 0, barrier = enable, hold = 0.
- Reset also clears the queue pointers, ms_now, the prescaler and the synchronisers. A reset mid-operation discards all records.
- Sensor latency: the raw rise is first sampled at edge k. The edge is detected after edge k+1. Records, pointers and pulse outputs update at edge k+2, so pulses are high in the cycle after edge k+2.
- hold updates one edge after the record state changes.
- Pulses last exactly one cycle. Back-to-back events on consecutive detected edges are all processed.
- Transit resolution is 1 ms, with quantisation error up to ±1 ms.
- Transits ≥ 2^WIDTH_MS ms alias. The system integrator sizes WIDTH_MS for this.

## Test plan
Bench parameters: SYS_FREQ=4000 (4 clk/ms), DEPTH=2, WIDTH_MS=9, MIN_MS=10.
- Paid vehicle: sensor1 rise, valid_Epass 2 cycles later, sensor2 rise 80 clk later → done, transit_ms=20±1, overspeed=0. Barrier goes to 1 and stays 1 until sensor3 falls. occupancy goes 1→0 at the sensor3 edge. violation stays 0.
- Unpaid vehicle: same stimulus without Epass → done, transit 20±1. Barrier stays 0. The sensor3 rise gives violation=1 for one cycle and occupancy=0.
- Overspeed across wrap: preset ms_now near 508, sensor1, then sensor2 16 clk later → transit_ms=4, overspeed=1. The result is correct across the 511→0 wrap.
- Full queue: three sensor1 rises with no exits → third gives err pulse, occupancy stays 2. A following sensor2 rise reports the first vehicle.
- Override: enable=1 with an empty queue → barrier=1 in the same cycle. A record pushed during enable is still measured.
- Reset mid-operation: occupancy=1, pulse reset_n low → all outputs at reset values. A subsequent sensor3 rise gives err=1, violation=0, occupancy=0.
